// File: rtl/rr_arbiter_reg_if.sv
// Request/grant bundle for the registered round-robin arbiter.
// The arbiter takes the master side; the requesting/consuming logic takes the slave side.
interface rr_arbiter_reg_if #(
  parameter int N_REQ = 4,
  parameter int W_IDX = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [W_IDX-1:0] gnt_idx;
  logic             gnt_valid;
  logic             gnt_ready;
  logic [15:0]      busy_cycles;

  modport master (
    input  req, gnt_ready,
    output gnt, gnt_idx, gnt_valid, busy_cycles
  );

  modport slave (
    output req, gnt_ready,
    input  gnt, gnt_idx, gnt_valid, busy_cycles
  );
endinterface

// File: rtl/rr_arbiter_reg.sv
// Registered round-robin arbiter: one-hot grant plus binary index, held stable until accepted,
// with back-to-back re-grant on handshake and a saturating stall counter.
module rr_arbiter_reg #(
  parameter int N_REQ = 4,
  parameter int W_IDX = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter_reg_if.master   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [N_REQ-1:0] mask_r, mask_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic [W_IDX-1:0] gnt_idx_r, gnt_idx_s;
  logic [15:0]      busy_r;
  logic [N_REQ-1:0] mask_above_s, eff_mask_s, hi_s, lo_s, sel_s;
  logic             handshake_s;

  function automatic logic [N_REQ-1:0] lowest_one(input logic [N_REQ-1:0] v);
    return v & ((~v) + N_REQ'(1));
  endfunction

  function automatic logic [W_IDX-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
    logic [W_IDX-1:0] idx;
    idx = {W_IDX{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) begin
        idx = idx | W_IDX'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Selection: on handshake the freshly computed mask is used so the winner drops to lowest priority.
  always_comb begin
    mask_above_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      mask_above_s[i] = (W_IDX'(i) > gnt_idx_r);
    end
    handshake_s = (state_r == GRANT) && bus.gnt_ready;
    if (handshake_s) begin
      eff_mask_s = mask_above_s;
    end else begin
      eff_mask_s = mask_r;
    end
    hi_s = lowest_one(bus.req & eff_mask_s);
    lo_s = lowest_one(bus.req);
    if (hi_s != {N_REQ{1'b0}}) begin
      sel_s = hi_s;
    end else begin
      sel_s = lo_s;
    end
  end

  // Next-state and next-grant logic.
  always_comb begin
    state_s   = state_r;
    mask_s    = mask_r;
    gnt_s     = gnt_r;
    gnt_idx_s = gnt_idx_r;
    case (state_r)
      IDLE: begin
        if (bus.req != {N_REQ{1'b0}}) begin
          state_s   = GRANT;
          gnt_s     = sel_s;
          gnt_idx_s = onehot_to_idx(sel_s);
        end else begin
          state_s   = IDLE;
        end
      end
      GRANT: begin
        if (bus.gnt_ready) begin
          mask_s = mask_above_s;
          if (sel_s != {N_REQ{1'b0}}) begin
            state_s   = GRANT;
            gnt_s     = sel_s;
            gnt_idx_s = onehot_to_idx(sel_s);
          end else begin
            state_s   = IDLE;
            gnt_s     = {N_REQ{1'b0}};
            gnt_idx_s = {W_IDX{1'b0}};
          end
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s   = IDLE;
        mask_s    = {N_REQ{1'b1}};
        gnt_s     = {N_REQ{1'b0}};
        gnt_idx_s = {W_IDX{1'b0}};
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      mask_r    <= {N_REQ{1'b1}};
      gnt_r     <= {N_REQ{1'b0}};
      gnt_idx_r <= {W_IDX{1'b0}};
    end else begin
      state_r   <= state_s;
      mask_r    <= mask_s;
      gnt_r     <= gnt_s;
      gnt_idx_r <= gnt_idx_s;
    end
  end

  // Stall monitor: counts presented-but-not-accepted cycles, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 16'h0000;
    end else if ((state_r == GRANT) && !bus.gnt_ready && (busy_r != 16'hffff)) begin
      busy_r <= busy_r + 16'h0001;
    end else begin
      busy_r <= busy_r;
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.gnt_idx     = gnt_idx_r;
  assign bus.gnt_valid   = (state_r == GRANT);
  assign bus.busy_cycles = busy_r;

endmodule
